seq_adder_nbit: RTL
===================

SEQ_ADDER_NBIT -- requirements
Module: seq_adder_nbit

Interface
REQ-001 Parameter BIT_WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK_WIDTH, default 4: bits added per cycle; BIT_WIDTH SHALL be an integer multiple of CHUNK_WIDTH; NUM_CHUNKS = BIT_WIDTH/CHUNK_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands a, b and carry_in are presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  BIT_WIDTH  first operand.
REQ-008 b  input  BIT_WIDTH  second operand.
REQ-009 carry_in  input  1  carry into bit 0.
REQ-010 out_valid  output  1  sum, carry_out and overflow are valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  BIT_WIDTH  a + b + carry_in, modulo 2^BIT_WIDTH.
REQ-013 carry_out  output  1  unsigned carry out of the MSB.
REQ-014 overflow  output  1  two's-complement signed overflow flag (see REQ-027).

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 On IDLE with in_valid=1, the block SHALL register a, b and carry_in, clear the chunk counter to 0 and go to CALC.
REQ-019 In CALC, each cycle SHALL add chunk k of both operands plus the running carry, write chunk k of the sum, register the chunk carry and increment k.
REQ-020 When k = NUM_CHUNKS-1, the FSM SHALL go to DONE on the same edge that writes the final chunk.
REQ-021 Latency: out_valid SHALL rise exactly NUM_CHUNKS cycles after the accepting edge (4 cycles at the defaults).
REQ-022 In DONE, sum, carry_out and overflow SHALL be held stable until out_valid and out_ready are both 1; the FSM then goes to IDLE.
REQ-023 An IDLE-to-CALC transition SHALL NOT occur in the cycle DONE exits; at most one transaction is in flight, so peak throughput is one result per NUM_CHUNKS+2 cycles.
REQ-024 in_valid and operand changes while in CALC or DONE SHALL be ignored and SHALL NOT corrupt the result.
REQ-025 Wrap-around: sum SHALL be modulo 2^BIT_WIDTH, with carry_out=1 whenever the true result is >= 2^BIT_WIDTH.
REQ-026 NUM_CHUNKS=1 SHALL be legal: CALC lasts one cycle.
REQ-027 overflow SHALL be 1 iff a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
REQ-028 Any X/Z on a, b or carry_in at an accepting edge SHALL raise a simulation-only $error; this check is not synthesised.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, in_ready=1 (once rst is low), out_valid=0, sum=0, carry_out=0, overflow=0, and chunk counter=0.
REQ-030 rst SHALL take priority over every other input in every state.
REQ-031 A reset asserted in CALC or DONE SHALL discard the transaction; no out_valid pulse SHALL follow it.

Configuration
REQ-032 Macro SEQ_ADDER_OVERFLOW_EN: when defined, overflow SHALL be computed per REQ-027 and registered with the result.
REQ-033 When SEQ_ADDER_OVERFLOW_EN is not defined, the overflow port SHALL remain present, be tied to constant 0, and no overflow logic SHALL be synthesised.

Structure
REQ-034 Package seq_adder_pkg SHALL hold the state enum type (IDLE, CALC, DONE) and the default width constants.
REQ-035 Sub-module adder_chunk (parameter CHUNK_WIDTH; ports a, b, carry_in, sum, carry_out) SHALL implement the per-cycle combinational ripple add.
REQ-036 seq_adder_nbit SHALL instantiate exactly one adder_chunk and SHALL select operand chunks with the counter.

Verification (BIT_WIDTH=16, CHUNK_WIDTH=4, macro defined unless stated)
REQ-037 a=0x1234, b=0x1111, cin=0 -> out_valid after 4 cycles, sum=0x2345, carry_out=0, overflow=0.
REQ-038 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0; a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1.
REQ-039 Hold out_ready=0 for 5 cycles after out_valid -> outputs stay unchanged, in_ready=0; then out_ready=1 -> IDLE the next cycle and in_ready=1.
REQ-040 Assert rst in the 2nd CALC cycle -> next cycle all outputs are 0 and the state is IDLE; no out_valid follows.
REQ-041 Toggle in_valid and operands during CALC -> the result matches the originally accepted operands.
REQ-042 Rebuild without the macro and apply a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=0.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// ---------------------------------------------------------------------------
// seq_adder_pkg
// Shared definitions for the chunk-serial adder:
//   - state_t          : FSM state encoding (IDLE, CALC, DONE)
//   - DEFAULT_BIT_WIDTH: default operand/sum width
//   - DEFAULT_CHUNK_WIDTH: default bits added per cycle
// ---------------------------------------------------------------------------
package seq_adder_pkg;

   localparam int DEFAULT_BIT_WIDTH   = 16;
   localparam int DEFAULT_CHUNK_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : seq_adder_pkg

// File: rtl/adder_chunk.sv
// ---------------------------------------------------------------------------
// adder_chunk
// Purely combinational ripple add of one CHUNK_WIDTH-bit slice.
// Ports:
//   a, b      [CHUNK_WIDTH-1:0] in  : operand slices
//   carry_in                    in  : carry into slice bit 0
//   sum       [CHUNK_WIDTH-1:0] out : slice sum
//   carry_out                   out : carry out of slice MSB
// ---------------------------------------------------------------------------
module adder_chunk #(
   parameter int CHUNK_WIDTH = 4
) (
   input  logic [CHUNK_WIDTH-1:0] a,
   input  logic [CHUNK_WIDTH-1:0] b,
   input  logic                   carry_in,
   output logic [CHUNK_WIDTH-1:0] sum,
   output logic                   carry_out
);

   // One extra bit on each term so the carry falls out of the top bit.
   assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, carry_in};

endmodule : adder_chunk

// File: rtl/seq_adder_nbit.sv
// ---------------------------------------------------------------------------
// seq_adder_nbit
// Chunk-serial adder: accepts a, b, carry_in in IDLE, adds one CHUNK_WIDTH
// slice per cycle in CALC (NUM_CHUNKS cycles), presents the result in DONE
// until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid only in DONE; the result
// holds stable while out_valid=1 and out_ready=0. At most one transaction
// is in flight; the DONE->IDLE edge never accepts new operands.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : operand handshake
//   a, b [BIT_WIDTH-1:0], carry_in : operands
//   out_valid / out_ready    : result handshake
//   sum [BIT_WIDTH-1:0], carry_out, overflow : result
//   dbg_state [1:0]          : current FSM state (state_t encoding)
//
// Configuration macro: SEQ_ADDER_OVERFLOW_EN
//   defined   -> signed overflow is computed and registered with the result
//   undefined -> overflow port tied to 0, no overflow logic
//
// BIT_WIDTH must be an integer multiple of CHUNK_WIDTH.
// ---------------------------------------------------------------------------
module seq_adder_nbit
   import seq_adder_pkg::*;
#(
   parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
   parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 carry_out,
   output logic                 overflow,
   output logic [1:0]           dbg_state
);

   localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
   // Counter needs at least one bit even when NUM_CHUNKS == 1.
   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_CHUNKS - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       k_q, k_d;
   logic [BIT_WIDTH-1:0]   a_q, a_d;
   logic [BIT_WIDTH-1:0]   b_q, b_d;
   // Holds carry_in after acceptance, then the running inter-chunk carry.
   logic                   carry_q, carry_d;
   logic [BIT_WIDTH-1:0]   sum_q, sum_d;
   logic                   cout_q, cout_d;

   logic [CHUNK_WIDTH-1:0] ch_a, ch_b, ch_sum;
   logic                   ch_cout;

   assign ch_a = a_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign ch_b = b_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];

   adder_chunk #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_chunk (
      .a         (ch_a),
      .b         (ch_b),
      .carry_in  (carry_q),
      .sum       (ch_sum),
      .carry_out (ch_cout)
   );

`ifdef SEQ_ADDER_OVERFLOW_EN
   logic ovf_q, ovf_d;
   // Final-chunk sum MSB is ch_sum's top bit; operand MSBs come from a_q/b_q.
   logic ovf_final;
   assign ovf_final = (a_q[BIT_WIDTH-1] == b_q[BIT_WIDTH-1]) &&
                      (ch_sum[CHUNK_WIDTH-1] != a_q[BIT_WIDTH-1]);
`endif

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      a_d       = a_q;
      b_d       = b_q;
      carry_d   = carry_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_d     = ovf_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = carry_in;
               k_d     = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
               ovf_d   = 1'b0;
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d[k_q*CHUNK_WIDTH +: CHUNK_WIDTH] = ch_sum;
            carry_d = ch_cout;
            if (k_q == LAST_K) begin
               // Final chunk written on the same edge that enters DONE.
               cout_d  = ch_cout;
`ifdef SEQ_ADDER_OVERFLOW_EN
               ovf_d   = ovf_final;
`endif
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign dbg_state = state_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
   assign overflow  = ovf_q;
`else
   assign overflow  = 1'b0;
`endif

`ifndef SYNTHESIS
   // Unknown operands at an accepting edge would silently poison the result.
   always @(posedge clk) begin
      if (!rst && state_q == IDLE && in_valid === 1'b1) begin
         if ($isunknown({a, b, carry_in})) begin
            $error("seq_adder_nbit: X/Z on a, b or carry_in at accepting edge");
         end
      end
   end
`endif

endmodule : seq_adder_nbit
